// File: rtl/qbus_irq_pkg.sv
// Shared definitions for the vectored-interrupt responder family:
// FSM encoding, default "no request" vector and vector alignment mask.
package qbus_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Vector handed to the CPU when istb arrives with nothing pending.
    localparam logic [15:0] NOVEC_DEFAULT = 16'o000;

    // Vectors are word aligned; the two low bits are always cleared.
    localparam logic [15:0] VEC_MASK = 16'hFFFC;

endpackage

// File: rtl/qbus_virq_responder_if.sv
// CPU-side vectored-interrupt pins.
//
// Handshake: the responder raises virq while a request is pending. The CPU
// raises istb and holds it until it sees iack. The responder raises iack
// with ivec valid and holds both stable for as long as istb stays high.
// When istb falls, iack and ivec drop on the next clock.
interface qbus_virq_if;
    logic        virq;
    logic        istb;
    logic [15:0] ivec;
    logic        iack;

    modport master (input virq, input ivec, input iack, output istb);
    modport slave  (output virq, output ivec, output iack, input istb);
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins. Reusable by any
// multi-source controller that needs an index plus a valid flag.
module irq_prio_enc #(
    parameter  int NCH = 4,
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    output logic [IW-1:0]  idx,
    output logic           valid
);

    // Scan from highest to lowest so the lowest set bit is written last.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/qbus_virq_responder.sv
// Vectored-interrupt responder: arbitrates device request levels, drives
// virq to the CPU and answers the vector-fetch strobe with ivec/iack,
// pulsing irq_ack to the device that was served.
module qbus_virq_responder
    import qbus_irq_pkg::*;
#(
    parameter int          NCH   = 4,
    parameter logic [15:0] NOVEC = NOVEC_DEFAULT
) (
    input  logic              clk_p,
    input  logic              rst_n,
    input  logic [NCH-1:0]    irq_req,
    input  logic [16*NCH-1:0] vec_tbl,
    output logic [NCH-1:0]    irq_ack,
    qbus_virq_if.slave        bus,
    output state_t            state
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [IW-1:0]  win;
    logic           win_valid;
    logic [15:0]    win_vec;
    logic [NCH-1:0] win_onehot;

    irq_prio_enc #(.NCH(NCH)) u_prio (
        .req   (irq_req),
        .idx   (win),
        .valid (win_valid)
    );

    // Select the winner's aligned vector and build its acknowledge mask.
    always_comb begin
        win_vec    = vec_tbl[int'(win) * 16 +: 16] & VEC_MASK;
        win_onehot = '0;
        for (int i = 0; i < NCH; i++) begin
            win_onehot[i] = (int'(win) == i);
        end
    end

    // Responder FSM; every output is a register updated here.
    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus.virq <= 1'b0;
            bus.iack <= 1'b0;
            bus.ivec <= 16'o0;
            irq_ack  <= '0;
        end else begin
            irq_ack <= '0;
            case (state)
                IDLE: begin
                    if (bus.istb) begin
                        // Arbitration uses only this cycle's request sample.
                        bus.virq <= 1'b0;
                        bus.iack <= 1'b1;
                        state    <= SERVE;
                        if (win_valid) begin
                            bus.ivec <= win_vec;
                            irq_ack  <= win_onehot;
                        end else begin
                            bus.ivec <= NOVEC;
                        end
                    end else begin
                        bus.virq <= |irq_req;
                    end
                end
                SERVE: begin
                    bus.virq <= 1'b0;
                    if (!bus.istb) begin
                        bus.iack <= 1'b0;
                        bus.ivec <= 16'o0;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Gives the served device a cycle to drop its level.
                    bus.virq <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.virq <= 1'b0;
                    bus.iack <= 1'b0;
                    bus.ivec <= 16'o0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qbus_virq_responder.sv
// Directed plus randomised bench for qbus_virq_responder with a scoreboard
// of expected vectors and acknowledge masks.
module tb_qbus_virq_responder;
    import qbus_irq_pkg::*;

    localparam int NCH = 4;

    logic            clk_p;
    logic            rst_n;
    logic [NCH-1:0]  irq_req;
    logic [16*NCH-1:0] vec_tbl;
    logic [NCH-1:0]  irq_ack;
    state_t          state;

    qbus_virq_if bus ();

    qbus_virq_responder #(.NCH(NCH), .NOVEC(16'o000)) dut (
        .clk_p   (clk_p),
        .rst_n   (rst_n),
        .irq_req (irq_req),
        .vec_tbl (vec_tbl),
        .irq_ack (irq_ack),
        .bus     (bus.slave),
        .state   (state)
    );

    // Clock / reset
    initial clk_p = 1'b0;
    always #5 clk_p = ~clk_p;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_vec_q[$];
    logic [15:0] exp_ack_q[$];
    logic [15:0] vecs[NCH];

    task automatic step();
        @(posedge clk_p);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_virq"}, {15'd0, bus.virq}, 16'd0);
        check({tag, "_iack"}, {15'd0, bus.iack}, 16'd0);
        check({tag, "_ivec"}, bus.ivec, 16'd0);
        check({tag, "_ack"}, {12'd0, irq_ack}, 16'd0);
        check({tag, "_state"}, {14'd0, state}, {14'd0, IDLE});
    endtask

    // Bench model: lowest set bit wins, vectors word aligned.
    function automatic int lowest_set(input logic [NCH-1:0] r);
        int w;
        w = -1;
        for (int i = NCH - 1; i >= 0; i--) if (r[i]) w = i;
        return w;
    endfunction

    // Raise istb with an expected outcome queued; compare one cycle later.
    task automatic serve(input string tag, input logic [15:0] ev, input logic [15:0] ea);
        logic [15:0] v;
        logic [15:0] a;
        exp_vec_q.push_back(ev);
        exp_ack_q.push_back(ea);
        bus.istb = 1'b1;
        step();
        check({tag, "_iack"}, {15'd0, bus.iack}, 16'd1);
        if (exp_vec_q.size() > 0 && exp_ack_q.size() > 0) begin
            v = exp_vec_q.pop_front();
            a = exp_ack_q.pop_front();
            check({tag, "_ivec"}, bus.ivec, v);
            check({tag, "_ack"}, {12'd0, irq_ack}, a);
        end
    endtask

    task automatic finish_serve(input string tag);
        bus.istb = 1'b0;
        step();
        check({tag, "_iack_drop"}, {15'd0, bus.iack}, 16'd0);
        check({tag, "_rel"}, {14'd0, state}, {14'd0, RELEASE});
        step();
        check({tag, "_idle"}, {14'd0, state}, {14'd0, IDLE});
    endtask

    initial begin
        logic [NCH-1:0] r;
        int w;

        vecs[0] = 16'o047;
        vecs[1] = 16'o064;
        vecs[2] = 16'o060;
        vecs[3] = 16'o100;
        vec_tbl = {vecs[3], vecs[2], vecs[1], vecs[0]};

        // Reset held with every input active
        rst_n    = 1'b0;
        irq_req  = 4'b1111;
        bus.istb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_outputs("reset");
        end
        irq_req  = '0;
        bus.istb = 1'b0;
        rst_n    = 1'b1;
        step();
        check_idle_outputs("post_reset");

        // Single request on channel 2
        irq_req = 4'b0100;
        step();
        check("single_virq", {15'd0, bus.virq}, 16'd1);
        serve("single", 16'o060, 16'b0100);
        irq_req = '0;
        step();
        check("single_ack_once", {12'd0, irq_ack}, 16'd0);
        check("single_hold_iack", {15'd0, bus.iack}, 16'd1);
        check("single_hold_ivec", bus.ivec, 16'o060);
        check("single_virq_off", {15'd0, bus.virq}, 16'd0);
        finish_serve("single");

        // Priority: 1 beats 3, 3 re-raises virq afterwards
        irq_req = 4'b1010;
        step();
        check("prio_virq", {15'd0, bus.virq}, 16'd1);
        serve("prio_a", 16'o064, 16'b0010);
        irq_req = 4'b1000;
        finish_serve("prio_a");
        check("prio_virq_idle_edge", {15'd0, bus.virq}, 16'd0);
        step();
        check("prio_virq_again", {15'd0, bus.virq}, 16'd1);
        serve("prio_b", 16'o100, 16'b1000);
        irq_req = '0;
        finish_serve("prio_b");

        // Withdrawn request: NOVEC, no acknowledge pulse
        irq_req = 4'b0001;
        step();
        irq_req = '0;
        step();
        check("wd_virq_low", {15'd0, bus.virq}, 16'd0);
        serve("withdrawn", 16'o000, 16'd0);
        finish_serve("withdrawn");

        // Stability while serving; vector low bits masked
        irq_req = 4'b0001;
        step();
        serve("stable", 16'o044, 16'b0001);
        for (int i = 0; i < 4; i++) begin
            irq_req = (i % 2 == 0) ? 4'b0010 : 4'b0011;
            step();
            check("stable_ivec", bus.ivec, 16'o044);
            check("stable_iack", {15'd0, bus.iack}, 16'd1);
            check("stable_ack", {12'd0, irq_ack}, 16'd0);
        end
        irq_req = '0;
        finish_serve("stable");

        // Persisting request is served again after RELEASE
        irq_req = 4'b0100;
        step();
        serve("persist_a", 16'o060, 16'b0100);
        finish_serve("persist_a");
        step();
        check("persist_virq", {15'd0, bus.virq}, 16'd1);
        serve("persist_b", 16'o060, 16'b0100);
        irq_req = '0;
        finish_serve("persist_b");

        // Reset in the middle of SERVE, then fresh service
        irq_req = 4'b0010;
        step();
        serve("midrst_a", 16'o064, 16'b0010);
        rst_n = 1'b0;
        step();
        check_idle_outputs("midrst");
        rst_n = 1'b1;
        serve("midrst_b", 16'o064, 16'b0010);
        irq_req = '0;
        finish_serve("midrst_b");

        // Random request patterns
        for (int k = 0; k < 8; k++) begin
            r = 4'($urandom_range(1, 15));
            irq_req = r;
            step();
            check("rand_virq", {15'd0, bus.virq}, 16'd1);
            w = lowest_set(r);
            serve("rand", vecs[w] & 16'hFFFC, 16'(1 << w));
            irq_req = '0;
            finish_serve("rand");
        end

        check("queue_empty", 16'(exp_vec_q.size() + exp_ack_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
